// File: rtl/bus_resolver_arb_if.sv
// Agent-side inputs and consumer-side outputs of the shared bus model.
interface bus_resolver_arb_if #(
  parameter int N_AGENTS = 4,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16
);
  logic [1:0]                mode;
  logic [N_AGENTS-1:0]       drv_en;
  logic [N_AGENTS*WIDTH-1:0] drv_data;
  logic                      clr_cnt;
  logic [WIDTH-1:0]          bus_q;
  logic [WIDTH-1:0]          z_mask;
  logic                      contention;
  logic [CNT_W-1:0]          contention_cnt;
  logic [N_AGENTS-1:0]       grant;

  modport master (
    output mode, drv_en, drv_data, clr_cnt,
    input  bus_q, z_mask, contention, contention_cnt, grant
  );

  modport slave (
    input  mode, drv_en, drv_data, clr_cnt,
    output bus_q, z_mask, contention, contention_cnt, grant
  );
endinterface

// File: rtl/bus_resolver_arb.sv
// Registered multi-driver bus: raw tri-state, wired-AND/OR, or round-robin
// arbitrated tri-state, with a bus keeper and a saturating contention counter.
module bus_resolver_arb #(
  parameter int N_AGENTS   = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_TENURE = 2,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  bus_resolver_arb_if.slave bus_if
);

  localparam int IDX_W = $clog2(N_AGENTS);
  localparam int TEN_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE - 1);

  typedef enum logic [1:0] {TRI_RAW = 2'd0, WAND = 2'd1, WOR = 2'd2, TRI_ARB = 2'd3} mode_e;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [N_AGENTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TEN_W-1:0]    tenure_q, tenure_d;
  logic [1:0]          mode_prev_q;
  logic [WIDTH-1:0]    bus_val_q, bus_val_d;
  logic [WIDTH-1:0]    z_mask_q, z_mask_d;
  logic                cont_q, cont_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                any_en;
  logic [WIDTH-1:0]    and_v, or_v, conflict, undriven, keep;
  logic [WIDTH-1:0]    owner_data;
  logic [IDX_W-1:0]    owner_idx, after_owner;
  logic [N_AGENTS-1:0] others;
  logic                mode_chg;

  // First set bit of req at or after start, scanning cyclically.
  function automatic logic [IDX_W-1:0] first_from(input logic [N_AGENTS-1:0] req,
                                                  input logic [IDX_W-1:0]    start);
    logic [IDX_W-1:0] r;
    logic             found;
    int               j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N_AGENTS; k++) begin
      j = int'(start) + k;
      if (j >= N_AGENTS) j = j - N_AGENTS;
      if (!found && req[j]) begin
        found = 1'b1;
        r     = IDX_W'(j);
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    any_en     = 1'b0;
    and_v      = '1;
    or_v       = '0;
    owner_data = '0;
    owner_idx  = '0;
    for (int i = 0; i < N_AGENTS; i++) begin
      if (bus_if.drv_en[i]) begin
        any_en = 1'b1;
        and_v  = and_v & bus_if.drv_data[i*WIDTH +: WIDTH];
        or_v   = or_v  | bus_if.drv_data[i*WIDTH +: WIDTH];
      end
      if (grant_q[i]) begin
        owner_data = bus_if.drv_data[i*WIDTH +: WIDTH];
        owner_idx  = IDX_W'(i);
      end
    end
  end

  // A bit conflicts when the enabled drivers disagree: their AND and OR differ.
  always_comb begin
    undriven  = {WIDTH{~any_en}};
    conflict  = any_en ? (and_v ^ or_v) : '0;
    keep      = conflict | undriven;
    bus_val_d = bus_val_q;
    z_mask_d  = undriven;
    cont_d    = 1'b0;
    case (bus_if.mode)
      TRI_RAW: begin
        bus_val_d = (bus_val_q & keep) | (or_v & ~keep);
        cont_d    = |conflict;
      end
      WAND:    if (any_en) bus_val_d = and_v;
      WOR:     if (any_en) bus_val_d = or_v;
      default: begin
        if (|grant_q) begin
          bus_val_d = owner_data;
          z_mask_d  = '0;
        end else begin
          z_mask_d  = '1;
        end
      end
    endcase

    cnt_d = cnt_q;
    if (bus_if.clr_cnt)               cnt_d = '0;
    else if (cont_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    tenure_d    = tenure_q;
    others      = bus_if.drv_en & ~grant_q;
    after_owner = (owner_idx == IDX_W'(N_AGENTS - 1)) ? '0 : owner_idx + IDX_W'(1);
    mode_chg    = (bus_if.mode != mode_prev_q);

    if ((bus_if.mode != TRI_ARB) || mode_chg) begin
      state_d  = IDLE;
      grant_d  = '0;
      tenure_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus_if.drv_en) begin
            grant_d  = N_AGENTS'(1) << first_from(bus_if.drv_en, rr_ptr_q);
            state_d  = GRANT;
            tenure_d = '0;
          end
        end
        GRANT: begin
          if (!(|(bus_if.drv_en & grant_q))) begin
            grant_d  = '0;
            rr_ptr_d = after_owner;
            state_d  = IDLE;
          end else if ((tenure_q == TEN_MAX) && (|others)) begin
            grant_d  = N_AGENTS'(1) << first_from(others, after_owner);
            tenure_d = '0;
          end else if (tenure_q != TEN_MAX) begin
            tenure_d = tenure_q + TEN_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      tenure_q    <= '0;
      mode_prev_q <= TRI_RAW;
      bus_val_q   <= '0;
      z_mask_q    <= '1;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      tenure_q    <= tenure_d;
      mode_prev_q <= bus_if.mode;
      bus_val_q   <= bus_val_d;
      z_mask_q    <= z_mask_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_if.bus_q          = bus_val_q;
  assign bus_if.z_mask         = z_mask_q;
  assign bus_if.contention     = cont_q;
  assign bus_if.contention_cnt = cnt_q;
  assign bus_if.grant          = grant_q;

endmodule

// File: tb/tb_bus_resolver_arb.sv
// Directed scenarios plus random traffic checked against a per-bit, per-agent reference model.
module tb_bus_resolver_arb;
  localparam int N       = 4;
  localparam int W       = 8;
  localparam int MAXT    = 2;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_resolver_arb_if #(.N_AGENTS(N), .WIDTH(W), .CNT_W(CW)) bif ();

  bus_resolver_arb #(.N_AGENTS(N), .WIDTH(W), .MAX_TENURE(MAXT), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [1:0]   mode_v;
  logic [N-1:0] en_v;
  logic [W-1:0] data_v [N];
  logic         clr_v;

  logic [W-1:0] m_bus, m_zm;
  logic         m_cont;
  int           m_cnt, m_owner, m_ten, m_rr;
  logic [1:0]   m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_bus = '0; m_zm = '1; m_cont = 1'b0; m_cnt = 0;
    m_owner = -1; m_ten = 0; m_rr = 0; m_prev = 2'd0;
  endtask

  task automatic drive();
    bif.mode    = mode_v;
    bif.drv_en  = en_v;
    bif.clr_cnt = clr_v;
    for (int i = 0; i < N; i++) bif.drv_data[i*W +: W] = data_v[i];
  endtask

  task automatic check_all();
    check("bus_q",          32'(bif.bus_q),          32'(m_bus));
    check("z_mask",         32'(bif.z_mask),         32'(m_zm));
    check("contention",     32'(bif.contention),     32'(m_cont));
    check("contention_cnt", 32'(bif.contention_cnt), 32'(m_cnt));
    check("grant",          32'(bif.grant),          32'(exp_grant()));
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step();
    logic [W-1:0] nbus, nzm;
    logic         ncont;
    int           ncnt, nowner, nten, nrr, c0, c1;
    logic [N-1:0] rest;
    drive();
    nbus = m_bus; nzm = '0; ncont = 1'b0;
    if (mode_v == 2'd3) begin
      if (m_owner >= 0) nbus = data_v[m_owner];
      else              nzm  = '1;
    end else begin
      for (int b = 0; b < W; b++) begin
        c0 = 0; c1 = 0;
        for (int i = 0; i < N; i++) if (en_v[i]) begin
          if (data_v[i][b]) c1++; else c0++;
        end
        if (c0 + c1 == 0)          nzm[b] = 1'b1;
        else if (mode_v == 2'd0) begin
          if (c0 > 0 && c1 > 0)    ncont = 1'b1;
          else                     nbus[b] = (c1 > 0);
        end else if (mode_v == 2'd1) nbus[b] = (c0 == 0);
        else                       nbus[b] = (c1 > 0);
      end
    end
    ncnt = clr_v ? 0 : ((ncont && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);

    nowner = m_owner; nten = m_ten; nrr = m_rr;
    if (mode_v != 2'd3 || mode_v != m_prev) begin
      nowner = -1; nten = 0;
    end else if (m_owner < 0) begin
      if (en_v != 0) begin nowner = first_req(en_v, m_rr); nten = 0; end
    end else if (!en_v[m_owner]) begin
      nowner = -1; nrr = (m_owner + 1) % N;
    end else begin
      rest = en_v;
      rest[m_owner] = 1'b0;
      if (m_ten == MAXT - 1 && rest != 0) begin
        nowner = first_req(rest, (m_owner + 1) % N); nten = 0;
      end else if (m_ten < MAXT - 1) begin
        nten = m_ten + 1;
      end
    end

    @(posedge clk);
    m_bus = nbus; m_zm = nzm; m_cont = ncont; m_cnt = ncnt;
    m_owner = nowner; m_ten = nten; m_rr = nrr; m_prev = mode_v;
    #1;
    check_all();
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    data_v[0] = d0; data_v[1] = d1; data_v[2] = d2; data_v[3] = d3;
  endtask

  logic [N-1:0] t4_seq [9];
  logic [N-1:0] prev_g;

  initial begin
    t4_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rst = 1'b1;
    mode_v = 2'd0; en_v = '0; clr_v = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    drive();
    model_reset();
    #3 check_all();
    #4 rst = 1'b0;

    // T1: single driver
    en_v = 4'b0001; set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    step();
    check("t1_bus", 32'(bif.bus_q), 32'h0000_00A5);

    // T2: raw contention, then undriven keeper
    en_v = 4'b0011; set_data(8'hF0, 8'h0F, 8'h00, 8'h00);
    step();
    check("t2_bus", 32'(bif.bus_q), 32'h0000_00A5);
    check("t2_cnt", 32'(bif.contention_cnt), 32'd1);
    en_v = 4'b0000;
    step();
    check("t2_zmask", 32'(bif.z_mask), 32'h0000_00FF);

    // T3: wired-AND, wired-OR, then keeper
    en_v = 4'b0111; set_data(8'hFF, 8'h0F, 8'h3C, 8'h00);
    mode_v = 2'd1; step();
    check("t3_wand", 32'(bif.bus_q), 32'h0000_000C);
    mode_v = 2'd2; step();
    check("t3_wor", 32'(bif.bus_q), 32'h0000_00FF);
    en_v = 4'b0000; step();
    check("t3_hold", 32'(bif.bus_q), 32'h0000_00FF);

    // T4: arbitrated rotation with all agents requesting
    mode_v = 2'd3; en_v = 4'b1111; set_data(8'h11, 8'h22, 8'h33, 8'h44);
    step();
    check("t4_chg_grant", 32'(bif.grant), 32'd0);
    prev_g = '0;
    for (int k = 0; k < 9; k++) begin
      step();
      check("t4_grant", 32'(bif.grant), 32'(t4_seq[k]));
      if (k > 0) check("t4_bus", 32'(bif.bus_q), 32'(data_v[$clog2(prev_g)]));
      prev_g = t4_seq[k];
    end

    // T5: counter saturation and clear priority
    mode_v = 2'd0; en_v = 4'b0011; set_data(8'hF0, 8'h0F, 8'h00, 8'h00);
    clr_v = 1'b1; step();
    check("t5_clr0", 32'(bif.contention_cnt), 32'd0);
    clr_v = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check("t5_sat", 32'(bif.contention_cnt), 32'(CNT_MAX));
    clr_v = 1'b1; step();
    check("t5_clr", 32'(bif.contention_cnt), 32'd0);
    clr_v = 1'b0;

    // T6: asynchronous reset in the middle of a grant
    mode_v = 2'd3; en_v = 4'b0110; set_data(8'h5A, 8'hC3, 8'h96, 8'h69);
    step(); step(); step();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    en_v = 4'b1111;
    step(); step();
    check("t6_first_grant", 32'(bif.grant), 32'd1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) mode_v = 2'($urandom_range(0, 3));
      en_v  = N'($urandom);
      clr_v = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) data_v[i] = W'($urandom);
      if ($urandom_range(0, 3) == 0) for (int i = 0; i < N; i++) data_v[i] = data_v[0];
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
